// File: rtl/ser_to_par_8_if.sv
// Bus bundle for the serial-to-parallel word collector: serial input side,
// control strobes and the parallel valid/ready output side.
interface ser_to_par_8_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic             Start;
  logic             Stop;
  logic             Serial_In;
  logic             Bit_En;
  logic             Data_Ready;
  logic             Clear_Ovf;
  logic [WIDTH-1:0] Data_Out;
  logic             Data_Valid;
  logic             Busy;
  logic [CW-1:0]    Bit_Count;
  logic             Overflow;

  // Producer/consumer side: drives the stream and accepts words.
  modport master (
    output Start, Stop, Serial_In, Bit_En, Data_Ready, Clear_Ovf,
    input  Data_Out, Data_Valid, Busy, Bit_Count, Overflow
  );

  // Collector side.
  modport slave (
    input  Start, Stop, Serial_In, Bit_En, Data_Ready, Clear_Ovf,
    output Data_Out, Data_Valid, Busy, Bit_Count, Overflow
  );
endinterface

// File: rtl/ser_to_par_8.sv
// Serial-in, parallel-out word collector: assembles LSB-first words from an
// enable-qualified bit stream and holds each word behind a valid/ready handshake.
module ser_to_par_8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  ser_to_par_8_if.slave    bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] word_c;
  logic             word_done_c;
  logic             xfer_c;
  logic             ovf_set_c;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: Start wins over Stop; otherwise hold.
  always_comb begin
    state_d = state_q;
    if (bus.Start) begin
      state_d = S_COLLECT;
    end else if (bus.Stop) begin
      state_d = S_IDLE;
    end
  end

  // Datapath and handshake next values.
  always_comb begin
    shift_d      = shift_q;
    bit_count_d  = bit_count_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    word_done_c  = 1'b0;
    ovf_set_c    = 1'b0;
    word_c       = {bus.Serial_In, shift_q[WIDTH-1:1]};
    xfer_c       = data_valid_q & bus.Data_Ready;

    if (bus.Start) begin
      // Realign: a same-cycle bit becomes bit 0 of the fresh word.
      shift_d     = '0;
      bit_count_d = '0;
      if (bus.Bit_En) begin
        shift_d     = {bus.Serial_In, (WIDTH-1)'(0)};
        bit_count_d = CW'(1);
      end
    end else if (bus.Stop) begin
      shift_d     = '0;
      bit_count_d = '0;
    end else if ((state_q == S_COLLECT) && bus.Bit_En) begin
      shift_d = word_c;
      if (bit_count_q == CW'(WIDTH - 1)) begin
        bit_count_d = '0;
        word_done_c = 1'b1;
      end else begin
        bit_count_d = bit_count_q + CW'(1);
      end
    end

    if (xfer_c) begin
      data_valid_d = 1'b0;
    end

    // A completion loads only into an empty or draining holding register.
    if (word_done_c) begin
      if (!data_valid_q || xfer_c) begin
        data_out_d   = word_c;
        data_valid_d = 1'b1;
      end else begin
        ovf_set_c = 1'b1;
      end
    end

    overflow_d = ovf_set_c | (overflow_q & ~bus.Clear_Ovf);
    busy_d     = (state_d == S_COLLECT);
  end

  // Datapath and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shift_q      <= '0;
      bit_count_q  <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bit_count_q  <= bit_count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.Data_Out   = data_out_q;
  assign bus.Data_Valid = data_valid_q;
  assign bus.Busy       = busy_q;
  assign bus.Bit_Count  = bit_count_q;
  assign bus.Overflow   = overflow_q;

endmodule
